timer_clock_divider: RTL and testbench

Divides the fast system clock CLK_IN down to a slow timing clock CLK_OUT. Parking-spot occupancy timers in time_counter clock their counters on CLK_OUT. Default ratio is 50 MHz to 1 Hz, so CLK_OUT edges mark one-second ticks. A one-cycle TICK strobe in the CLK_IN domain is also provided for synchronous consumers.

---
 rtl/timer_clock_divider_if.sv | 8 +
 rtl/timer_clock_divider.sv | 47 ++++
 tb/tb_timer_clock_divider.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/timer_clock_divider_if.sv
// Output bundle of the clock divider: the divided clock and its CLK_IN-domain tick strobe.
interface timer_clock_divider_if;
  logic CLK_OUT;
  logic TICK;

  modport master (output CLK_OUT, TICK);
  modport slave  (input  CLK_OUT, TICK);
endinterface

// File: rtl/timer_clock_divider.sv
// Divides CLK_IN by N = CLK_IN_FREQ / CLK_OUT_FREQ into a registered, glitch-free CLK_OUT
// (low for L cycles, high for H cycles) plus a one-cycle TICK on each CLK_OUT rise.
module timer_clock_divider #(
  parameter int unsigned CLK_IN_FREQ  = 50_000_000,
  parameter int unsigned CLK_OUT_FREQ = 1
) (
  input  logic                         CLK_IN,
  input  logic                         RST_N,
  timer_clock_divider_if.master        out
);

  localparam int unsigned N  = CLK_IN_FREQ / CLK_OUT_FREQ;
  localparam int unsigned H  = N / 2;
  localparam int unsigned L  = N - H;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (N < 2) begin : g_bad_ratio
      $error("timer_clock_divider: CLK_IN_FREQ / CLK_OUT_FREQ must be at least 2");
    end
  endgenerate

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Outputs are decoded from the next count so they can be registered in the
  // same edge that updates cnt, keeping cnt off any output path.
  always_comb begin
    cnt_next = cnt + 1'b1;
    if (cnt == CW'(N - 1)) cnt_next = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      cnt         <= '0;
      out.CLK_OUT <= 1'b0;
      out.TICK    <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      out.CLK_OUT <= (cnt_next >= CW'(L));
      out.TICK    <= (cnt_next == CW'(L));
    end
  end

endmodule

// File: tb/tb_timer_clock_divider.sv
// Self-checking bench: several divider ratios share one clock and reset; an edge-count model
// predicts every output each cycle, with directed literal checks and randomized async resets.
`timescale 1ns/1ps
module tb_timer_clock_divider;

  localparam int NUM = 5;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  // Effective divisors of the instances below, in the same order.
  int unsigned n_tab [NUM] = '{8, 5, 2, 7, 50_000_000};

  timer_clock_divider_if if8 ();
  timer_clock_divider_if if5 ();
  timer_clock_divider_if if2 ();
  timer_clock_divider_if if7 ();
  timer_clock_divider_if ifd ();

  timer_clock_divider #(.CLK_IN_FREQ(8),  .CLK_OUT_FREQ(1)) dut8 (.CLK_IN(clk), .RST_N(rst_n), .out(if8));
  timer_clock_divider #(.CLK_IN_FREQ(5),  .CLK_OUT_FREQ(1)) dut5 (.CLK_IN(clk), .RST_N(rst_n), .out(if5));
  timer_clock_divider #(.CLK_IN_FREQ(2),  .CLK_OUT_FREQ(1)) dut2 (.CLK_IN(clk), .RST_N(rst_n), .out(if2));
  timer_clock_divider #(.CLK_IN_FREQ(22), .CLK_OUT_FREQ(3)) dut7 (.CLK_IN(clk), .RST_N(rst_n), .out(if7));
  timer_clock_divider                                       dutd (.CLK_IN(clk), .RST_N(rst_n), .out(ifd));

  logic [NUM-1:0] co;
  logic [NUM-1:0] tk;
  assign co = {ifd.CLK_OUT, if7.CLK_OUT, if2.CLK_OUT, if5.CLK_OUT, if8.CLK_OUT};
  assign tk = {ifd.TICK,    if7.TICK,    if2.TICK,    if5.TICK,    if8.TICK};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: number of rising edges since reset was last released.
  int unsigned k;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  function automatic logic exp_clk(input int unsigned n, input int unsigned e);
    return (e % n) >= (n - n / 2);
  endfunction

  function automatic logic exp_tick(input int unsigned n, input int unsigned e);
    return (e % n) == (n - n / 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NUM; i++) begin
      check($sformatf("clk_out[N=%0d] edge %0d", n_tab[i], k), 32'(co[i]), 32'(exp_clk(n_tab[i], k)));
      check($sformatf("tick[N=%0d] edge %0d", n_tab[i], k), 32'(tk[i]), 32'(exp_tick(n_tab[i], k)));
    end
  end

  int unsigned rise8[$];
  int unsigned rise5[$];
  int unsigned tick2[$];
  int          tick8_cnt;
  logic        prev8, prev5;

  initial begin
    rst_n = 1'b0;
    #1;
    check("reset clk_out", 32'(co), 32'd0);
    check("reset tick", 32'(tk), 32'd0);
    repeat (3) @(negedge clk);
    check("reset held clk_out", 32'(co), 32'd0);
    #2 rst_n = 1'b1;

    // Directed window: record rise and tick positions for 40 edges after release.
    prev8 = 1'b0; prev5 = 1'b0; tick8_cnt = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (co[0] && !prev8) rise8.push_back(e);
      if (co[1] && !prev5) rise5.push_back(e);
      if (tk[0]) tick8_cnt++;
      if (tk[2]) tick2.push_back(e);
      prev8 = co[0];
      prev5 = co[1];
    end
    check("N=8 tick count in 40", tick8_cnt, 5);
    check("N=8 rise count", rise8.size(), 5);
    check("N=5 rise count", rise5.size(), 8);
    check("N=2 tick count", tick2.size(), 20);
    if (rise8.size() >= 3) begin
      check("N=8 first rise", rise8[0], 4);
      check("N=8 second rise", rise8[1], 12);
      check("N=8 third rise", rise8[2], 20);
    end
    if (rise5.size() >= 3) begin
      check("N=5 first rise", rise5[0], 3);
      check("N=5 second rise", rise5[1], 8);
      check("N=5 third rise", rise5[2], 13);
    end
    if (tick2.size() >= 3) begin
      check("N=2 first tick", tick2[0], 1);
      check("N=2 second tick", tick2[1], 3);
      check("N=2 third tick", tick2[2], 5);
    end

    // Mid-period async reset while the N=8 output is high.
    for (int i = 0; i < 8 && (k % 8) != 6; i++) @(posedge clk);
    #1;
    check("N=8 high before mid reset", 32'(co[0]), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("N=8 clk_out drops on async reset", 32'(co[0]), 32'd0);
    check("all outputs drop on async reset", 32'(co | tk), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("N=8 low at edge 3 after release", 32'(co[0]), 32'd0);
    @(posedge clk); #1;
    check("N=8 rises at edge 4 after release", 32'(co[0]), 32'd1);
    check("N=8 tick at edge 4 after release", 32'(tk[0]), 32'd1);

    // Randomized run lengths and asynchronous reset pulses at random offsets.
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(70, 1)) @(negedge clk);
      #($urandom_range(4, 1)) rst_n = 1'b0;
      #0.5;
      check("random async reset outputs", 32'(co | tk), 32'd0);
      repeat ($urandom_range(3, 1)) @(negedge clk);
      #($urandom_range(4, 1)) rst_n = 1'b1;
    end
    repeat (50) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
